// File: rtl/pixel_stream_pkg.sv
// Shared constants, helper functions and state encoding for the pixel stream transmitter.
// Optional feature macro: PIXEL_TX_ZERO_PAD_EN (adds a one-pixel zero border around each frame).
package pixel_stream_pkg;

    localparam int DEF_IN_HEIGHT  = 4;
    localparam int DEF_IN_WIDTH   = 4;
    localparam int DEF_IN_CHANNEL = 2;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_WORD_WIDTH = 8;

    // Channel words carried by one stream beat, and beats needed per pixel.
    localparam int WORDS               = DEF_WIDTH / DEF_WORD_WIDTH;
    localparam int TRANSFERS_PER_PIXEL = DEF_IN_CHANNEL / WORDS;

`ifdef PIXEL_TX_ZERO_PAD_EN
    localparam int PAD_BORDER = 1;
`else
    localparam int PAD_BORDER = 0;
`endif

    // Dimensions of the transmitted frame, including any zero border.
    localparam int FRAME_ROWS = DEF_IN_HEIGHT + 2 * PAD_BORDER;
    localparam int FRAME_COLS = DEF_IN_WIDTH + 2 * PAD_BORDER;

    // EMPTY: nothing held; DATA: sending a real pixel; PAD: sending a border pixel.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DATA  = 2'd1,
        PAD   = 2'd2
    } txState_e;

    function automatic int calcWords(input int width, input int wordWidth);
        return width / wordWidth;
    endfunction

    function automatic int calcTransfers(input int channels, input int width, input int wordWidth);
        return channels / calcWords(width, wordWidth);
    endfunction

    function automatic int frameDim(input int n);
        return n + 2 * PAD_BORDER;
    endfunction

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_tx_beat_serializer.sv
// Holds the accepted pixel and walks through it one stream beat at a time.
module beat_serializer
    import pixel_stream_pkg::*;
#(
    parameter int IN_CHANNEL = DEF_IN_CHANNEL,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
)
(
    input  logic                             clk_i,
    input  logic                             rstN_i,
    input  logic                             load_i,
    input  logic [IN_CHANNEL*WORD_WIDTH-1:0] pixel_i,
    input  logic                             advance_i,
    output logic [WIDTH-1:0]                 data_o,
    output logic                             lastBeat_o
);

    localparam int T      = calcTransfers(IN_CHANNEL, WIDTH, WORD_WIDTH);
    localparam int PIX_W  = IN_CHANNEL * WORD_WIDTH;
    localparam int BEAT_W = cntWidth(T);

    logic [PIX_W-1:0]          pixel_q;
    logic [PIX_W-1:0]          pixel_d;
    logic [BEAT_W-1:0]         beat_q;
    logic [BEAT_W-1:0]         beat_d;
    logic [T-1:0][WIDTH-1:0]   beats;

    assign beats      = pixel_q;
    assign data_o     = beats[beat_q];
    assign lastBeat_o = (beat_q == BEAT_W'(T - 1));

    // Capture a new pixel on accept and step the beat index on each handshake.
    always_comb begin
        pixel_d = pixel_q;
        beat_d  = beat_q;
        if (advance_i) begin
            beat_d = lastBeat_o ? '0 : beat_q + 1'b1;
        end
        if (load_i) begin
            pixel_d = pixel_i;
            beat_d  = '0;
        end
    end

    // Pixel register and beat counter, cleared immediately on reset.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            pixel_q <= '0;
            beat_q  <= '0;
        end else begin
            pixel_q <= pixel_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Pixel-to-AXI4-stream transmitter: serializes whole pixels into beats and frames them.
// Optional feature macro: PIXEL_TX_ZERO_PAD_EN (emits a zero border of pixels around each frame).
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int IN_HEIGHT  = DEF_IN_HEIGHT,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int IN_CHANNEL = DEF_IN_CHANNEL,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
)
(
    input  logic                             i_aclk,
    input  logic                             i_aresetn,
    input  logic                             i_pix_valid,
    output logic                             o_pix_ready,
    input  logic [IN_CHANNEL*WORD_WIDTH-1:0] i_pix_data,
    output logic                             o_tvalid,
    input  logic                             i_tready,
    output logic [WIDTH-1:0]                 o_tdata,
    output logic                             o_tlast,
    output logic                             o_frame_done
);

    localparam int ROWS  = frameDim(IN_HEIGHT);
    localparam int COLS  = frameDim(IN_WIDTH);
    localparam int ROW_W = cntWidth(ROWS);
    localparam int COL_W = cntWidth(COLS);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    txState_e          state_q;
    txState_e          state_d;
    logic              tvalid_q;
    logic              tvalid_d;
    logic              frameDone_q;
    logic              frameDone_d;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_d;
    logic [COL_W-1:0]  col_q;
    logic [COL_W-1:0]  col_d;

    logic              handshake;
    logic              lastBeat;
    logic              pixelDone;
    logic              lastCol;
    logic              lastRow;
    logic              frameEnd;
    logic              atOrigin;
    logic [ROW_W-1:0]  nextRow;
    logic [COL_W-1:0]  nextCol;
    logic              curBorder;
    logic              nextBorder;
    logic              pixAccept;
    logic [WIDTH-1:0]  serData;

    assign handshake = tvalid_q && i_tready;
    assign pixelDone = handshake && lastBeat;
    assign lastCol   = (col_q == COL_LAST);
    assign lastRow   = (row_q == ROW_LAST);
    assign frameEnd  = pixelDone && lastCol && lastRow;
    assign atOrigin  = (row_q == '0) && (col_q == '0);
    assign nextCol   = lastCol ? '0 : col_q + 1'b1;
    assign nextRow   = lastCol ? (lastRow ? '0 : row_q + 1'b1) : row_q;

`ifdef PIXEL_TX_ZERO_PAD_EN
    assign curBorder  = (row_q == '0) || (row_q == ROW_LAST) ||
                        (col_q == '0) || (col_q == COL_LAST);
    assign nextBorder = (nextRow == '0) || (nextRow == ROW_LAST) ||
                        (nextCol == '0) || (nextCol == COL_LAST);
    assign o_tdata    = (state_q == PAD) ? '0 : serData;
`else
    assign curBorder  = 1'b0;
    assign nextBorder = 1'b0;
    assign o_tdata    = serData;
`endif

    // A pixel is taken when idle on an interior position, or back-to-back as the
    // held pixel's last beat leaves and the following position is interior too.
    assign o_pix_ready = ((state_q == EMPTY) && !curBorder) ||
                         ((state_q == DATA) && pixelDone && !nextBorder);
    assign pixAccept   = i_pix_valid && o_pix_ready;

    assign o_tvalid     = tvalid_q;
    assign o_tlast      = tvalid_q && lastBeat && lastCol && lastRow;
    assign o_frame_done = frameDone_q;

    beat_serializer #(
        .IN_CHANNEL (IN_CHANNEL),
        .WIDTH      (WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk_i      (i_aclk),
        .rstN_i     (i_aresetn),
        .load_i     (pixAccept),
        .pixel_i    (i_pix_data),
        .advance_i  (handshake),
        .data_o     (serData),
        .lastBeat_o (lastBeat)
    );

    // Next-state decisions: border pixels start once a frame is under way or a
    // pixel is waiting, so an idle link stays quiet between frames.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        frameDone_d = frameEnd;
        case (state_q)
            EMPTY: begin
                if (pixAccept) begin
                    state_d = DATA;
                end else if (curBorder && (i_pix_valid || !atOrigin)) begin
                    state_d = PAD;
                end
            end
            DATA, PAD: begin
                if (pixelDone) begin
                    if (pixAccept) begin
                        state_d = DATA;
                    end else if (nextBorder && !frameEnd) begin
                        state_d = PAD;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (pixelDone) begin
            row_d = nextRow;
            col_d = nextCol;
        end
        tvalid_d = (state_d != EMPTY);
    end

    // FSM state, frame position and registered stream flags.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q     <= EMPTY;
            tvalid_q    <= 1'b0;
            frameDone_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            tvalid_q    <= tvalid_d;
            frameDone_q <= frameDone_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter IN_HEIGHT, default 4, image height in pixels.
REQ-002 SHALL have parameter IN_WIDTH, default 4, image width in pixels.
REQ-003 SHALL have parameter IN_CHANNEL, default 2, channels per pixel; must be a multiple of WIDTH/WORD_WIDTH.
REQ-004 SHALL have parameter WIDTH, default 8, AXI4-stream data width; must be a multiple of WORD_WIDTH.
REQ-005 SHALL have parameter WORD_WIDTH, default 8, width of each channel value.
REQ-006 SHALL have port i_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_aresetn, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port i_pix_valid, input, 1, a whole pixel is offered.
REQ-009 SHALL have port o_pix_ready, output, 1, pixel accepted when high with i_pix_valid.
REQ-010 SHALL have port i_pix_data, input, IN_CHANNEL*WORD_WIDTH, channel c at bits [WORD_WIDTH*c +: WORD_WIDTH].
REQ-011 SHALL have port o_tvalid, output, 1, AXI4-stream valid.
REQ-012 SHALL have port i_tready, input, 1, AXI4-stream ready.
REQ-013 SHALL have port o_tdata, output, WIDTH, stream beat.
REQ-014 SHALL have port o_tlast, output, 1, last beat of frame.
REQ-015 SHALL have port o_frame_done, output, 1, single-cycle end-of-frame pulse.

Function
REQ-016 SHALL split each pixel into T = IN_CHANNEL/(WIDTH/WORD_WIDTH) beats; beat k word j = channel k*WORDS+j at bits [WORD_WIDTH*j +: WORD_WIDTH].
REQ-017 SHALL use FSM states EMPTY, DATA and PAD; EMPTY->DATA on pixel accept, DATA->EMPTY on last-beat handshake with no new pixel, DATA->DATA when a new pixel is accepted in that same cycle.
REQ-018 SHALL drive o_pix_ready = (state==EMPTY) or (state==DATA and last beat of held pixel handshaking); combinational path from i_tready only.
REQ-019 SHALL present the first beat of an accepted pixel in the cycle after acceptance, registered.
REQ-020 SHALL sustain one beat per cycle across pixel boundaries when i_pix_valid and i_tready stay high.
REQ-021 SHALL hold o_tdata, o_tlast stable and o_tvalid high while o_tvalid && !i_tready.
REQ-022 SHALL advance beat, column and row counters only on o_tvalid && i_tready; each wraps to 0 at its limit.
REQ-023 SHALL assert o_tlast only on the last beat of the last pixel of a frame.
REQ-024 SHALL pulse o_frame_done for exactly one cycle, the cycle after the o_tlast handshake.
REQ-025 SHALL ignore i_pix_data when o_pix_ready is low.

Reset
REQ-026 SHALL clear state to EMPTY, all counters to 0, o_tvalid, o_tlast, o_frame_done to 0, and o_tdata to 0 immediately on i_aresetn low.
REQ-027 SHALL discard any partially sent frame on reset; the next frame starts at row 0, column 0, beat 0.

Configuration
REQ-028 SHALL, when PIXEL_TX_ZERO_PAD_EN is defined, emit a frame of (IN_HEIGHT+2)x(IN_WIDTH+2) pixels: border pixels are T all-zero beats in state PAD, with o_pix_ready low and no input consumed.
REQ-029 SHALL, when PIXEL_TX_ZERO_PAD_EN is undefined, emit IN_HEIGHT x IN_WIDTH pixels; PAD is unreachable and may be removed.

Structure
REQ-030 SHALL place WORDS, TRANSFERS_PER_PIXEL, frame dimension constants and the state encoding in shared package pixel_stream_pkg.
REQ-031 SHALL use one sub-module, beat_serializer, which holds the pixel register and beat counter and produces o_tdata; the top owns the FSM, the frame counters and padding.

Verification
REQ-032 SHALL cover: defaults, one pixel 0x0201, i_tready=1 -> beats 0x01 then 0x02 in consecutive cycles, first beat one cycle after acceptance.
REQ-033 SHALL cover: i_tready low for 3 cycles during beat 0x01 -> o_tdata stays 0x01 and o_tvalid stays high; 0x02 follows after ready returns.
REQ-034 SHALL cover: 16 back-to-back pixels with ready always high -> 32 beats in 32 cycles, o_tlast on beat 32 only, o_frame_done the next cycle.
REQ-035 SHALL cover: PIXEL_TX_ZERO_PAD_EN, 16 pixels -> 72 beats, first 14 beats zero, o_tlast on beat 72.
REQ-036 SHALL cover: reset after 10 beats -> o_tvalid low during reset; the next 16-pixel frame gives o_tlast on its 32nd beat.
